// File: rtl/uart_autobaud.sv
// Measures a 0x55 sync character on RX and reports the UART clocks-per-bit.
// Optional AUTOBAUD_GLITCH_FILTER_EN adds a 3-sample majority filter on the synchronized RX.
module uart_autobaud #(
    parameter int CNT_W = 19
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        uart_rx_i,
    input  logic        start_i,
    input  logic [15:0] la_cpb_i,
    output logic [15:0] clks_per_bit_o,
    output logic        cpb_valid_o,
    output logic        busy_o,
    output logic        err_o,
    output logic        rx_sync_o
);

    typedef enum logic [2:0] {IDLE, ARM, WAIT_START, MEASURE, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] c_q, c_d;
    logic [2:0]       e_q, e_d;
    logic [15:0]      r_q, r_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             rxs_prev_q, rxs_prev_d;
    logic             rxs;
    logic             fall;
    logic [31:0]      r_full;
    logic             r_ok;

`ifdef AUTOBAUD_GLITCH_FILTER_EN
    logic hist1_q, hist1_d;
    logic hist2_q, hist2_d;

    assign hist1_d = sync2_q;
    assign hist2_d = hist1_q;
    assign rxs     = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
        end
    end
`else
    assign rxs = sync2_q;
`endif

    assign sync1_d    = uart_rx_i;
    assign sync2_d    = sync1_q;
    assign rxs_prev_d = rxs;
    assign fall       = ~rxs & rxs_prev_q;

    // Rounded divide by 8: C spans eight bit-times between the 1st and 5th falling edges.
    assign r_full = 32'({1'b0, c_q} + (CNT_W+1)'(4)) >> 3;
    assign r_ok   = (r_full >= 32'd4) && (r_full <= 32'h0000_FFFF);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        e_d     = e_q;
        r_d     = r_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = ARM;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ARM: begin
                // Wait for an idle-high line so a line already low is not a start edge.
                if (rxs) state_d = WAIT_START;
            end
            WAIT_START: begin
                if (fall) begin
                    state_d = MEASURE;
                    c_d     = CNT_W'(1);
                    e_d     = 3'd1;
                end
            end
            MEASURE: begin
                if (fall && (e_q == 3'd4)) begin
                    e_d = 3'd5;
                    if (r_ok) begin
                        r_d     = r_full[15:0];
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (c_q == '1) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    c_d = c_q + CNT_W'(1);
                    if (fall) e_d = e_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ARM) || (state_d == WAIT_START) || (state_d == MEASURE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            c_q        <= '0;
            e_q        <= '0;
            r_q        <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            e_q        <= e_d;
            r_q        <= r_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            rxs_prev_q <= rxs_prev_d;
        end
    end

    assign clks_per_bit_o = valid_q ? r_q : la_cpb_i;
    assign cpb_valid_o    = valid_q;
    assign busy_o         = busy_q;
    assign err_o          = err_q;
    assign rx_sync_o      = rxs;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: 0x55 frames at several bit rates, error paths and reset.
// The counter is narrowed to 12 bits so the timeout path is reachable in a short run.
module tb_uart_autobaud;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        start;
    logic [15:0] la;
    logic [15:0] cpb;
    logic        valid;
    logic        busy;
    logic        err;
    logic        rxs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_autobaud #(.CNT_W(12)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .uart_rx_i      (rx),
        .start_i        (start),
        .la_cpb_i       (la),
        .clks_per_bit_o (cpb),
        .cpb_valid_o    (valid),
        .busy_o         (busy),
        .err_o          (err),
        .rx_sync_o      (rxs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
    endtask

    // Drives the first nb bits of an 8N1 0x55 frame, n cycles per bit.
    task automatic send55(input int n, input bit jit, input bit chk, input int nb);
        logic [9:0] fr;
        int d;
        fr = 10'b1010101010;
        for (int i = 0; i < nb; i++) begin
            d = n;
            if (jit) d = n + ((i % 3 == 0) ? 1 : (i % 3 == 1) ? -1 : 0);
            rx = fr[i];
            if (chk && i == 8) begin
                cyc(1);
                check("lat_sync1", {31'd0, valid}, 32'd0);
                cyc(1);
                check("lat_edge", {31'd0, valid}, 32'd0);
                cyc(1);
                check("lat_valid", {31'd0, valid}, 32'd1);
                cyc(d - 3);
            end else begin
                cyc(d);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        rx    = 1'b1;
        start = 1'b0;
        la    = 16'h01B2;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        check("rst_cpb", {16'd0, cpb}, 32'h01B2);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rxs", {31'd0, rxs}, 32'd1);

        arm();
        check("arm_busy", {31'd0, busy}, 32'd1);
        send55(100, 1'b0, 1'b1, 10);
        cyc(5);
        check("c100_cpb", {16'd0, cpb}, 32'd100);
        check("c100_err", {31'd0, err}, 32'd0);
        check("c100_busy", {31'd0, busy}, 32'd0);

        send55(20, 1'b0, 1'b0, 10);
        cyc(5);
        check("done_hold_cpb", {16'd0, cpb}, 32'd100);
        check("done_hold_valid", {31'd0, valid}, 32'd1);

        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("rearm_valid", {31'd0, valid}, 32'd0);
        check("rearm_cpb", {16'd0, cpb}, 32'h01B2);
        cyc(3);
        send55(103, 1'b1, 1'b0, 10);
        cyc(5);
        check("c103_cpb", {16'd0, cpb}, 32'd103);
        check("c103_valid", {31'd0, valid}, 32'd1);

        arm();
        send55(2, 1'b0, 1'b0, 10);
        cyc(5);
        check("c2_err", {31'd0, err}, 32'd1);
        check("c2_valid", {31'd0, valid}, 32'd0);
        check("c2_cpb", {16'd0, cpb}, 32'h01B2);
        check("c2_busy", {31'd0, busy}, 32'd0);

        arm();
        check("to_err_clr", {31'd0, err}, 32'd0);
        rx = 1'b0;
        cyc(10);
        rx = 1'b1;
        cyc(4087);
        check("to_err_before", {31'd0, err}, 32'd0);
        check("to_busy_before", {31'd0, busy}, 32'd1);
        cyc(1);
        check("to_err_at", {31'd0, err}, 32'd1);
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_cpb", {16'd0, cpb}, 32'h01B2);

        la = 16'h0777;
        arm();
        send55(50, 1'b0, 1'b0, 5);
        check("mid_busy", {31'd0, busy}, 32'd1);
        check("mid_rxs_low", {31'd0, rxs}, 32'd0);
        rst = 1'b1;
        #1;
        check("mrst_valid", {31'd0, valid}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_err", {31'd0, err}, 32'd0);
        check("mrst_rxs", {31'd0, rxs}, 32'd1);
        check("mrst_cpb", {16'd0, cpb}, 32'h0777);
        cyc(1);
        rst = 1'b0;
        rx  = 1'b1;
        cyc(3);
        arm();
        send55(50, 1'b0, 1'b1, 10);
        cyc(5);
        check("c50_cpb", {16'd0, cpb}, 32'd50);
        check("c50_valid", {31'd0, valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
